// File: rtl/bgm_track_sequencer.sv
// Background-music sequencer: picks a track from scene/boss, inserts a muted
// gap on every change, and steps the note address once per beat.
module bgm_track_sequencer #(
  parameter int unsigned BEAT_DIV    = 12500000,
  parameter int unsigned GAP_BEATS   = 2,
  parameter int unsigned LOOP_LEN    = 64,
  parameter int unsigned ONESHOT_LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] scene,
  input  logic       boss,
  output logic [2:0] track_sel,
  output logic [7:0] note_idx,
  output logic       mute,
  output logic       beat_tick,
  output logic       song_done
);

  localparam int unsigned DW = $clog2(BEAT_DIV);
  localparam int unsigned GW = (GAP_BEATS > 1) ? $clog2(GAP_BEATS) : 1;

  localparam logic [DW-1:0] DIV_LAST     = DW'(BEAT_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_BEATS - 1);
  localparam logic [7:0]    LOOP_LAST    = 8'(LOOP_LEN - 1);
  localparam logic [7:0]    ONESHOT_LAST = 8'(ONESHOT_LEN - 1);

  typedef enum logic [1:0] {
    S_GAP,
    S_PLAY,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    TRK_START = 3'd0,
    TRK_GAME  = 3'd1,
    TRK_BOSS  = 3'd2,
    TRK_WIN   = 3'd3,
    TRK_LOSE  = 3'd4,
    TRK_NONE  = 3'd7
  } track_e;

  state_e          state_q, state_d;
  track_e          track_q, track_d;
  track_e          target;
  logic [7:0]      note_q,  note_d;
  logic            mute_q,  mute_d;
  logic [DW-1:0]   div_q,   div_d;
  logic [GW-1:0]   gap_q,   gap_d;
  logic            beat_q,  beat_d;
  logic            done_q,  done_d;
  logic            tick;
  logic            oneshot;

  always_comb begin
    target = TRK_NONE;
    unique case (scene)
      2'b00:   target = TRK_START;
      2'b01:   target = boss ? TRK_BOSS : TRK_GAME;
      2'b10:   target = TRK_WIN;
      default: target = TRK_LOSE;
    endcase
  end

  assign tick    = (div_q == DIV_LAST);
  assign oneshot = (track_q == TRK_WIN) || (track_q == TRK_LOSE);

  always_comb begin
    state_d = state_q;
    track_d = track_q;
    note_d  = note_q;
    mute_d  = mute_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    gap_d   = gap_q;
    beat_d  = tick;
    done_d  = 1'b0;

    unique case (state_q)
      S_GAP: begin
        mute_d = 1'b1;
        note_d = '0;
        if (tick) begin
          if (gap_q == GAP_LAST) begin
            // Target is sampled only here, so changes during the gap never restart it.
            state_d = S_PLAY;
            track_d = target;
            mute_d  = 1'b0;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end

      S_PLAY: begin
        if (target != track_q) begin
          state_d = S_GAP;
          mute_d  = 1'b1;
          note_d  = '0;
          div_d   = '0;
          gap_d   = '0;
        end else if (tick) begin
          if (oneshot) begin
            if (note_q == ONESHOT_LAST) begin
              state_d = S_DONE;
              mute_d  = 1'b1;
              done_d  = 1'b1;
            end else begin
              note_d = note_q + 1'b1;
            end
          end else begin
            note_d = (note_q == LOOP_LAST) ? '0 : note_q + 1'b1;
          end
        end
      end

      default: begin
        if (target != track_q) begin
          state_d = S_GAP;
          mute_d  = 1'b1;
          note_d  = '0;
          div_d   = '0;
          gap_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_GAP;
      track_q <= TRK_NONE;
      note_q  <= '0;
      mute_q  <= 1'b1;
      div_q   <= '0;
      gap_q   <= '0;
      beat_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      track_q <= track_d;
      note_q  <= note_d;
      mute_q  <= mute_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
    end
  end

  assign track_sel = track_q;
  assign note_idx  = note_q;
  assign mute      = mute_q;
  assign beat_tick = beat_q;
  assign song_done = done_q;

endmodule

// File: tb/tb_bgm_track_sequencer.sv
// Bench for bgm_track_sequencer: directed scenario followed by random scene
// changes and async resets, all checked against an elapsed-time reference model.
module tb_bgm_track_sequencer;

  localparam int unsigned BD = 4;
  localparam int unsigned GB = 2;
  localparam int unsigned LL = 4;
  localparam int unsigned OL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] scene;
  logic       boss;
  logic [2:0] track_sel;
  logic [7:0] note_idx;
  logic       mute;
  logic       beat_tick;
  logic       song_done;

  always #5 clk = ~clk;

  bgm_track_sequencer #(
    .BEAT_DIV   (BD),
    .GAP_BEATS  (GB),
    .LOOP_LEN   (LL),
    .ONESHOT_LEN(OL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scene    (scene),
    .boss     (boss),
    .track_sel(track_sel),
    .note_idx (note_idx),
    .mute     (mute),
    .beat_tick(beat_tick),
    .song_done(song_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: segment kind (0 gap, 1 playing, 2 finished) plus edges
  // elapsed since the segment's beat alignment point.
  int m_seg;
  int m_k;
  int m_trk;
  int m_tick;
  int m_done;

  function automatic int tgt_of(input logic [1:0] s, input logic b);
    case (s)
      2'b00:   return 0;
      2'b01:   return b ? 2 : 1;
      2'b10:   return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int exp_note();
    if (m_seg == 0) return 0;
    if (m_seg == 2) return int'(OL) - 1;
    if (m_trk >= 3) return m_k / int'(BD);
    return (m_k / int'(BD)) % int'(LL);
  endfunction

  task automatic model_reset();
    m_seg  = 0;
    m_k    = 0;
    m_trk  = 7;
    m_tick = 0;
    m_done = 0;
  endtask

  task automatic model_edge();
    int t;
    t      = tgt_of(scene, boss);
    m_tick = ((m_k % int'(BD)) == int'(BD) - 1) ? 1 : 0;
    m_done = 0;
    if (m_seg == 0) begin
      if (m_k == int'(GB * BD) - 1) begin
        m_seg = 1;
        m_trk = t;
        m_k   = 0;
      end else begin
        m_k++;
      end
    end else if (t != m_trk) begin
      m_seg = 0;
      m_k   = 0;
    end else begin
      m_k++;
      if (m_seg == 1 && m_trk >= 3 && m_k == int'(OL * BD)) begin
        m_seg  = 2;
        m_done = 1;
      end
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("track_sel", int'(track_sel), m_trk);
    check("note_idx",  int'(note_idx),  exp_note());
    check("mute",      int'(mute),      (m_seg != 1) ? 1 : 0);
    check("beat_tick", int'(beat_tick), m_tick);
    check("song_done", int'(song_done), m_done);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_all();
  endtask

  task automatic async_reset(input int unsigned dly);
    #(dly);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int done_cnt;
    bit found;
    rst   = 1'b1;
    scene = 2'b00;
    boss  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    for (int e = 1; e <= 8; e++) begin
      cycle();
      if (e == 7) check("pre_gap_end_track", int'(track_sel), 7);
      if (e == 8) begin
        check("start_track", int'(track_sel), 0);
        check("start_mute",  int'(mute), 0);
        check("start_note",  int'(note_idx), 0);
      end
    end
    repeat (20) cycle();

    scene = 2'b01;
    cycle();
    check("chg_mute", int'(mute), 1);
    check("chg_note", int'(note_idx), 0);
    cycle();
    boss = 1'b1;
    repeat (7) cycle();
    check("boss_track", int'(track_sel), 2);
    check("boss_mute",  int'(mute), 0);

    scene = 2'b10;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      done_cnt += int'(song_done);
    end
    check("win_done_once", done_cnt, 1);
    check("win_note_hold", int'(note_idx), int'(OL) - 1);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      done_cnt += int'(song_done);
    end
    check("win_no_repeat", done_cnt, 0);

    scene = 2'b00;
    repeat (12) cycle();
    scene = 2'b10;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_seg == 1 && m_trk == 3 && m_k == int'(OL * BD) - 1) found = 1'b1;
      else cycle();
    end
    check("wait_final_tick", int'(found), 1);
    scene = 2'b11;
    cycle();
    check("race_no_done", int'(song_done), 0);
    check("race_mute",    int'(mute), 1);
    repeat (8) cycle();
    check("lose_track", int'(track_sel), 4);

    repeat (6) cycle();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_track", int'(track_sel), 7);
    check("arst_mute",  int'(mute), 1);
    check_all();
    repeat (2) cycle();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      if (e == 7) check("rst_gap_track", int'(track_sel), 7);
      if (e == 8) check("rst_target_track", int'(track_sel), 4);
    end

    for (int it = 0; it < 300; it++) begin
      int unsigned hold;
      scene = 2'($urandom_range(0, 3));
      boss  = 1'($urandom);
      hold  = $urandom_range(1, 30);
      for (int unsigned c = 0; c < hold; c++) begin
        if (c == hold / 2 && $urandom_range(0, 3) == 0) boss = ~boss;
        cycle();
      end
      if ($urandom_range(0, 19) == 0) async_reset($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bgm_track_sequencer.md
Name: bgm_track_sequencer

Overview:
- Owns background-music track selection for the audio path.
- Watches the game scene and boss flag, and inserts a muted gap on every track change.
- Drives the track select and note index that feed the per-track note ROMs and the frequency mux.
- Loops the start/game/boss tracks; plays win/lose once, then holds silence.

Parameters:
BEAT_DIV, 12500000, clk cycles per note beat (min 2)
GAP_BEATS, 2, muted beats inserted between tracks (min 1)
LOOP_LEN, 64, notes in looping tracks (start/game/boss), 2..256
ONESHOT_LEN, 32, notes in one-shot tracks (win/lose), 2..256

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
scene  in  2  00 start, 01 game, 10 win, 11 lose
boss  in  1  boss phase flag; only meaningful when scene==01
track_sel  out  3  0 start, 1 game, 2 boss, 3 win, 4 lose, 7 none
note_idx  out  8  current note address into selected track ROM
mute  out  1  1 = audio path must output freq 0
beat_tick  out  1  one-cycle pulse at each beat boundary
song_done  out  1  one-cycle pulse when a one-shot track finishes

Behaviour:
- Single clock domain: clk. rst is asynchronous and active-high.
- Target track (combinational):
  - scene 00 -> 0
  - scene 01 with boss=0 -> 1
  - scene 01 with boss=1 -> 2
  - scene 10 -> 3
  - scene 11 -> 4
  - boss is ignored for all other scenes.
- Reset values:
  - state GAP, track_sel=7, note_idx=0, mute=1, beat_tick=0, song_done=0.
  - div_cnt=0, gap_cnt=0.
- div_cnt counts 0..BEAT_DIV-1 and wraps.
  - tick condition: div_cnt==BEAT_DIV-1.
  - beat_tick is registered: high on the cycle after the tick edge, 1 cycle wide. It pulses in every state.
- States:
  - GAP: mute=1, note_idx=0.
    - Each tick increments gap_cnt.
    - On a tick with gap_cnt==GAP_BEATS-1: track_sel<=target, note_idx<=0, mute<=0, div_cnt<=0, gap_cnt<=0 -> PLAY.
    - Gap length is exactly GAP_BEATS*BEAT_DIV cycles.
  - PLAY: mute=0. Each tick increments note_idx.
    - Looping track (0/1/2): at LOOP_LEN-1 wrap to 0 and stay in PLAY.
    - One-shot track (3/4): on tick at ONESHOT_LEN-1 -> DONE, mute<=1, note_idx holds at ONESHOT_LEN-1, song_done pulses for 1 cycle.
  - DONE: mute=1, track_sel held, note_idx held, no further song_done pulses.
- Track change:
  - In PLAY or DONE, if target != track_sel -> GAP next edge.
  - That edge sets mute<=1, note_idx<=0, div_cnt<=0, gap_cnt<=0. track_sel holds its old value until the gap ends.
- Target change during GAP:
  - No restart. The track latched at gap end is the target sampled on that final edge.
  - Returning to the same track after leaving it always takes a full gap.
- Simultaneous events:
  - Track change and tick on the same edge: the change wins; note_idx does not advance.
  - Track change on the final one-shot tick: the change wins; no song_done pulse.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronous). Sequencing resumes from GAP.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan (BEAT_DIV=4, GAP_BEATS=2, LOOP_LEN=4, ONESHOT_LEN=3):
- Release rst with scene=00, boss=0:
  - track_sel=7, mute=1 for 7 edges.
  - On edge 8: track_sel=0, mute=0, note_idx=0.
  - beat_tick pulses every 4 cycles.
- Continue scene=00 for 20 cycles: note_idx steps 0,1,2,3,0,1 every 4 cycles and wraps at 3.
- scene=01 with boss toggled 0->1 mid-note:
  - Next edge: mute=1, note_idx=0.
  - After 8 cycles: track_sel=2 (not 1), mute=0.
- scene=10:
  - After the gap: track_sel=3 and note_idx goes 0,1,2.
  - On the tick after note 2: single-cycle song_done=1, mute=1, note_idx stays 2.
  - No further pulses over 40 cycles.
- scene=11 asserted on the same edge as the final win tick: song_done stays 0, GAP entered, track_sel=4 after 8 cycles.
- Assert rst asynchronously mid-PLAY, between clock edges: outputs go to reset values before the next edge; after release, track_sel=7 for 7 edges, then the scene target appears.
